// File: rtl/serializer_pkg.sv
// Shared types for the parallel-to-serial shifter.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serializer_m.sv
// Parallel-to-serial shifter with valid/ready load, shift stall and a done pulse.
// Back-to-back words go out gaplessly when the next load lands on the final bit.
module serializer_m
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             enb,
    output logic             sout,
    output logic             sframe,
    output logic             done
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             adv;
    logic             hs;

    assign last       = (state == SHIFT) && (cnt == LAST);
    assign adv        = (state == SHIFT) && enb;
    assign load_ready = (state == IDLE) || (last && enb);
    assign hs         = load_valid && load_ready;

    // The output end is the MSB or LSB; the register always moves toward it.
    assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign sout    = (state == SHIFT) && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    assign sframe  = (state == SHIFT);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= adv && last;
            if (hs) begin
                sreg  <= d;
                cnt   <= '0;
                state <= SHIFT;
            end else if (adv) begin
                if (last) begin
                    state <= IDLE;
                    sreg  <= '0;
                    cnt   <= '0;
                end else begin
                    sreg <= shifted;
                    cnt  <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serializer_m.sv
// Directed bench: MSB-first and LSB-first instances share stimulus; a bit-queue scoreboard checks both.
module tb_serializer_m;

    logic       clk;
    logic       rst_;
    logic [7:0] d;
    logic       load_valid;
    logic       enb;
    logic       ready_m, sout_m, sframe_m, done_m;
    logic       ready_l, sout_l, sframe_l, done_l;

    int checks   = 0;
    int failures = 0;

    bit   qm[$];
    bit   ql[$];
    logic m_busy;
    logic done_exp;

    serializer_m #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_(rst_), .d(d), .load_valid(load_valid), .load_ready(ready_m),
        .enb(enb), .sout(sout_m), .sframe(sframe_m), .done(done_m)
    );

    serializer_m #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_(rst_), .d(d), .load_valid(load_valid), .load_ready(ready_l),
        .enb(enb), .sout(sout_l), .sframe(sframe_l), .done(done_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        qm.delete();
        ql.delete();
        m_busy   = 1'b0;
        done_exp = 1'b0;
    endtask

    // One clock: check load_ready before the edge, advance the scoreboard, check outputs after.
    task automatic tick();
        logic rdy_exp, hs, fin;
        #2;
        rdy_exp = !m_busy || (qm.size() == 1 && enb);
        chk("load_ready_m", ready_m, rdy_exp);
        chk("load_ready_l", ready_l, rdy_exp);
        hs  = load_valid && rdy_exp;
        fin = m_busy && enb && (qm.size() == 1);
        @(posedge clk);
        if (m_busy && enb) begin
            qm.delete(0);
            ql.delete(0);
        end
        if (hs) begin
            for (int i = 7; i >= 0; i--) qm.push_back(d[i]);
            for (int i = 0; i <= 7; i++) ql.push_back(d[i]);
        end
        m_busy   = (qm.size() != 0);
        done_exp = fin;
        #1;
        chk("sframe_m", sframe_m, m_busy);
        chk("sframe_l", sframe_l, m_busy);
        chk("sout_m", sout_m, m_busy ? logic'(qm[0]) : 1'b0);
        chk("sout_l", sout_l, m_busy ? logic'(ql[0]) : 1'b0);
        chk("done_m", done_m, done_exp);
        chk("done_l", done_l, done_exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_       = 1'b0;
        d          = 8'h00;
        load_valid = 1'b0;
        enb        = 1'b1;
        model_clear();
        #3;
        chk("rst_sout", sout_m, 1'b0);
        chk("rst_sframe", sframe_m, 1'b0);
        chk("rst_done", done_m, 1'b0);
        chk("rst_ready", ready_m, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2 rst_ = 1'b1;

        // Single word A5, continuous enable, both bit orders
        load_valid = 1'b1; d = 8'hA5;
        tick();
        load_valid = 1'b0; d = 8'h00;
        ticks(10);

        // FF then 00 back-to-back with load_valid held
        load_valid = 1'b1; d = 8'hFF;
        tick();
        d = 8'h00;
        ticks(8);
        load_valid = 1'b0;
        ticks(10);

        // Stall for three cycles while bit 2 is on the line
        load_valid = 1'b1; d = 8'hA5;
        tick();
        load_valid = 1'b0;
        ticks(2);
        enb = 1'b0;
        ticks(3);
        enb = 1'b1;
        ticks(8);

        // Offer 3C mid-word: must be ignored
        load_valid = 1'b1; d = 8'hC3;
        tick();
        d = 8'h3C;
        ticks(3);
        load_valid = 1'b0;
        ticks(7);

        // Reset in the middle of F0, then 81 loaded while enb=0
        load_valid = 1'b1; d = 8'hF0;
        tick();
        load_valid = 1'b0;
        ticks(4);
        #1 rst_ = 1'b0;
        #1;
        chk("arst_sout", sout_m, 1'b0);
        chk("arst_sframe", sframe_m, 1'b0);
        chk("arst_ready", ready_m, 1'b1);
        chk("arst_done", done_m, 1'b0);
        model_clear();
        #2 rst_ = 1'b1;
        enb = 1'b0; load_valid = 1'b1; d = 8'h81;
        tick();
        load_valid = 1'b0;
        tick();
        enb = 1'b1;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serializer_m.md
SERIALIZER_M -- requirements
Module: serializer_m

Interface
REQ-001 Parameter WIDTH, default 8, meaning parallel word width in bits; legal range WIDTH >= 2.
REQ-002 Parameter MSB_FIRST, default 1, meaning 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 clk  input  1  meaning sole clock; all state updates on posedge.
REQ-004 rst_  input  1  meaning asynchronous active-low reset.
REQ-005 d  input  WIDTH  meaning parallel word to transmit.
REQ-006 load_valid  input  1  meaning d holds a word offered for transmission.
REQ-007 load_ready  output  1  meaning the block accepts d on this edge if load_valid=1.
REQ-008 enb  input  1  meaning shift enable; 0 stalls transmission.
REQ-009 sout  output  1  meaning serial data bit.
REQ-010 sframe  output  1  meaning sout carries a valid data bit this cycle.
REQ-011 done  output  1  meaning one-cycle pulse after the last bit of a word.

Function
REQ-012 The block SHALL implement two states, IDLE and SHIFT.
REQ-013 Handshake SHALL occur at a posedge where load_valid=1 and load_ready=1; d is captured only then.
REQ-014 load_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only when bit count = WIDTH-1 and enb=1; else 0.
REQ-015 In IDLE, handshake SHALL load the shift register with d, clear the bit count to 0 and enter SHIFT; handshake does not depend on enb.
REQ-016 In SHIFT, sframe SHALL be 1 and sout SHALL equal the current bit (MSB if MSB_FIRST=1, else LSB) of the shift register.
REQ-017 In IDLE, sframe and sout SHALL be 0.
REQ-018 In SHIFT with enb=1, each posedge SHALL shift the register one position toward the output end and increment the bit count.
REQ-019 In SHIFT with enb=0, shift register, bit count, state and sout SHALL hold; sframe stays 1.
REQ-020 First bit SHALL appear on sout the cycle after handshake; a word occupies exactly WIDTH enabled SHIFT cycles.
REQ-021 At the posedge ending bit count WIDTH-1 with enb=1: without handshake, enter IDLE; with handshake, reload d, clear count, stay in SHIFT (gapless back-to-back).
REQ-022 done SHALL be a registered pulse, high for exactly one cycle after the edge that completes bit WIDTH-1, in both cases of REQ-021.
REQ-023 load_valid while load_ready=0 SHALL be ignored; d changes in SHIFT SHALL not affect sout.
REQ-024 Bit counter width SHALL be $clog2(WIDTH); no wrap beyond WIDTH-1.

Reset
REQ-025 rst_=0 SHALL immediately force state IDLE, shift register 0, bit count 0, done 0, hence sout=0, sframe=0, load_ready=1.
REQ-026 Reset during SHIFT SHALL abort the word with no done pulse; after rst_ deasserts, the next handshake starts a fresh word.

Structure
REQ-027 The state enum typedef (IDLE, SHIFT) SHALL live in the shared package serializer_pkg.
REQ-028 The block SHALL be a single module with no sub-module instances.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, enb=1, load 8'hA5 -> sout 1,0,1,0,0,1,0,1 on cycles 1-8, sframe high 8 cycles, done high cycle 9 only.
REQ-030 MSB_FIRST=0, load 8'hA5 -> sout 1,0,1,0,0,1,0,1 (LSB first) with identical sframe/done timing.
REQ-031 8'hFF then 8'h00 with load_valid held -> sframe high 16 contiguous cycles, sout 8x1 then 8x0, done pulse after cycles 8 and 16.
REQ-032 8'hA5 with enb=0 for 3 cycles after bit 2 -> sout holds bit 2 for 4 cycles, sframe stays 1, done at cycle 12.
REQ-033 rst_ pulsed low at bit 4 of 8'hF0 -> sout/sframe drop to 0 asynchronously, no done, load_ready=1; next load 8'h81 transmits 1,0,0,0,0,0,0,1.
REQ-034 load_valid=1 with d=8'h3C during mid-word SHIFT -> ignored, load_ready=0, current word unaltered.
